// File: rtl/cluster_pwr_seq_ctrl_pkg.sv
// Shared types and defaults for the cluster power sequencer.
// State encoding, default hold lengths and the hold-to-counter-load helper.
package cluster_seq_pkg;

    typedef enum logic [3:0] {
        OFF,
        PWR_UP,
        CLK_EN,
        RST_REL,
        BOOT,
        ON,
        DRAIN,
        RST_ASSERT,
        CLK_DIS,
        PWR_DN
    } cl_seq_state_e;

    localparam int unsigned CL_SEQ_RST_CYCLES     = 16;
    localparam int unsigned CL_SEQ_TIMEOUT_CYCLES = 200;

    // A state held N cycles loads N-1; zero is treated as a 1-cycle hold.
    function automatic int unsigned hold_load(input int unsigned cycles);
        return (cycles == 0) ? 0 : cycles - 1;
    endfunction

endpackage

// File: rtl/cl_seq_cnt.sv
// Loadable down-counter shared by every timed state of the sequencer.
// Saturates at zero; expired_o is high while the count is zero.
module cl_seq_cnt #(
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [CNT_WIDTH-1:0] val_i,
    output logic                 expired_o
);

    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (load_i) begin
            r_cnt <= val_i;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign expired_o = (r_cnt == '0);

endmodule

// File: rtl/cluster_pwr_seq_ctrl.sv
// Cluster power-up/boot and drain/power-down sequencer; outputs registered from next state.
// Optional drain timeout enabled by defining CLUSTER_SEQ_TIMEOUT_EN.
module cluster_pwr_seq_ctrl
    import cluster_seq_pkg::*;
#(
    parameter int unsigned BOOT_ADDR_WIDTH = 64,
    parameter int unsigned CNT_WIDTH       = 8,
    parameter int unsigned RST_CYCLES      = CL_SEQ_RST_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES  = CL_SEQ_TIMEOUT_CYCLES
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_on_i,
    input  logic                       req_off_i,
    input  logic [BOOT_ADDR_WIDTH-1:0] boot_addr_i,
    input  logic                       byp_i,
    input  logic [CNT_WIDTH-1:0]       settle_cycles_i,
    input  logic                       cluster_busy_i,
    output logic                       cluster_pow_o,
    output logic                       cluster_byp_o,
    output logic                       cluster_clk_en_o,
    output logic                       cluster_rstn_o,
    output logic                       cluster_fetch_enable_o,
    output logic [BOOT_ADDR_WIDTH-1:0] cluster_boot_addr_o,
    output logic                       seq_busy_o,
    output logic                       on_o,
    output logic                       done_o,
    output logic                       timeout_o
);

    localparam logic [CNT_WIDTH-1:0] RST_LOAD     = CNT_WIDTH'(hold_load(RST_CYCLES));
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LOAD = CNT_WIDTH'(hold_load(TIMEOUT_CYCLES));

    cl_seq_state_e          r_state;
    cl_seq_state_e          w_next;
    logic                   w_load;
    logic [CNT_WIDTH-1:0]   w_val;
    logic [CNT_WIDTH-1:0]   w_settle_val;
    logic                   w_expired;
    logic                   w_timeout;
    logic                   w_req_on;
    logic                   w_req_off;

    logic                       r_pow, r_byp, r_clk_en, r_rstn, r_fetch;
    logic                       r_seq_busy, r_on, r_done, r_timeout;
    logic [BOOT_ADDR_WIDTH-1:0] r_boot_addr;

    cl_seq_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (w_load),
        .val_i     (w_val),
        .expired_o (w_expired)
    );

    assign w_req_on     = req_on_i & ~req_off_i;
    assign w_req_off    = req_off_i & ~req_on_i;
    assign w_settle_val = (settle_cycles_i == '0) ? '0 : settle_cycles_i - 1'b1;

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_val     = '0;
        w_timeout = 1'b0;
        case (r_state)
            OFF: if (w_req_on) begin
                w_next = PWR_UP; w_load = 1'b1; w_val = w_settle_val;
            end
            PWR_UP: if (w_expired) begin
                w_next = CLK_EN; w_load = 1'b1; w_val = RST_LOAD;
            end
            CLK_EN:  if (w_expired) w_next = RST_REL;
            RST_REL: w_next = BOOT;
            BOOT:    w_next = ON;
            // The timeout load is harmless when the timeout is disabled: DRAIN then ignores the counter.
            ON: if (w_req_off) begin
                w_next = DRAIN; w_load = 1'b1; w_val = TIMEOUT_LOAD;
            end
            DRAIN: begin
                if (!cluster_busy_i) begin
                    w_next = RST_ASSERT; w_load = 1'b1; w_val = RST_LOAD;
                end
`ifdef CLUSTER_SEQ_TIMEOUT_EN
                else if (w_expired) begin
                    w_next = RST_ASSERT; w_load = 1'b1; w_val = RST_LOAD; w_timeout = 1'b1;
                end
`endif
            end
            RST_ASSERT: if (w_expired) w_next = CLK_DIS;
            CLK_DIS: begin
                w_next = PWR_DN; w_load = 1'b1; w_val = w_settle_val;
            end
            PWR_DN:  if (w_expired) w_next = OFF;
            default: w_next = OFF;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= OFF;
            r_pow       <= 1'b0;
            r_byp       <= 1'b0;
            r_clk_en    <= 1'b0;
            r_rstn      <= 1'b0;
            r_fetch     <= 1'b0;
            r_seq_busy  <= 1'b0;
            r_on        <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_boot_addr <= '0;
        end else begin
            r_state    <= w_next;
            r_pow      <= (w_next != OFF) && (w_next != PWR_DN);
            r_clk_en   <= w_next inside {CLK_EN, RST_REL, BOOT, ON, DRAIN, RST_ASSERT};
            r_rstn     <= w_next inside {RST_REL, BOOT, ON, DRAIN};
            r_fetch    <= w_next inside {BOOT, ON};
            r_seq_busy <= (w_next != OFF) && (w_next != ON);
            r_on       <= (w_next == ON);
            r_done     <= (w_next != r_state) && (w_next inside {ON, OFF});
            r_timeout  <= w_timeout;
            if (r_state == OFF && w_req_on) begin
                r_boot_addr <= boot_addr_i;
                r_byp       <= byp_i;
            end
        end
    end

    assign cluster_pow_o          = r_pow;
    assign cluster_byp_o          = r_byp;
    assign cluster_clk_en_o       = r_clk_en;
    assign cluster_rstn_o         = r_rstn;
    assign cluster_fetch_enable_o = r_fetch;
    assign cluster_boot_addr_o    = r_boot_addr;
    assign seq_busy_o             = r_seq_busy;
    assign on_o                   = r_on;
    assign done_o                 = r_done;
    assign timeout_o              = r_timeout;

endmodule

// File: tb/tb_cluster_pwr_seq_ctrl.sv
// Self-checking bench for cluster_pwr_seq_ctrl: expected output timelines are derived
// arithmetically from request time, settle time, reset hold and drain release time.
module tb_cluster_pwr_seq_ctrl;

    localparam int R  = 16;
    localparam int T  = 200;
    localparam int AW = 64;
    localparam int CW = 8;
`ifdef CLUSTER_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, req_on, req_off, byp, busy;
    logic [AW-1:0] boot_addr;
    logic [CW-1:0] settle;
    logic          pow, byp_o, clk_en, rstn, fetch, sbusy, on, done, tmo;
    logic [AW-1:0] boot_addr_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cluster_pwr_seq_ctrl #(
        .BOOT_ADDR_WIDTH (AW),
        .CNT_WIDTH       (CW),
        .RST_CYCLES      (R),
        .TIMEOUT_CYCLES  (T)
    ) dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .req_on_i               (req_on),
        .req_off_i              (req_off),
        .boot_addr_i            (boot_addr),
        .byp_i                  (byp),
        .settle_cycles_i        (settle),
        .cluster_busy_i         (busy),
        .cluster_pow_o          (pow),
        .cluster_byp_o          (byp_o),
        .cluster_clk_en_o       (clk_en),
        .cluster_rstn_o         (rstn),
        .cluster_fetch_enable_o (fetch),
        .cluster_boot_addr_o    (boot_addr_o),
        .seq_busy_o             (sbusy),
        .on_o                   (on),
        .done_o                 (done),
        .timeout_o              (tmo)
    );

    function automatic logic [7:0] outv();
        return {pow, clk_en, rstn, fetch, sbusy, on, done, tmo};
    endfunction

    // n = cycles since the request edge (n=1 is the first cycle showing its effect).
    function automatic logic [7:0] up_exp(input int n, input int s);
        int on_t = 3 + s + R;
        return {1'b1, n >= 1 + s, n >= 1 + s + R, n >= 2 + s + R,
                n < on_t, n >= on_t, n == on_t, 1'b0};
    endfunction

    function automatic logic [7:0] down_exp(input int n, input int s, input int eb, input bit tflag);
        int off_t = eb + R + 2 + s;
        return {n <= eb + R + 1, n <= eb + R, n <= eb, 1'b0,
                n < off_t, 1'b0, n == off_t, tflag && (n == eb + 1)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic power_up(input int sraw, input bit inj, input bit abort);
        int s = (sraw == 0) ? 1 : sraw;
        int on_t = 3 + s + R;
        logic [AW-1:0] addr = {$urandom, $urandom};
        logic b = 1'($urandom);
        settle = CW'(sraw); boot_addr = addr; byp = b; req_on = 1'b1;
        tick();
        req_on = 1'b0; boot_addr = ~addr; byp = ~b; settle = CW'($urandom);
        for (int n = 1; n <= on_t + 2; n++) begin
            if (abort && n == 1 + s) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                chk("abort_outs", 64'(outv()), 64'd0);
                chk("abort_addr", boot_addr_o, 64'd0);
                chk("abort_byp", 64'(byp_o), 64'd0);
                return;
            end
            chk("up_outs", 64'(outv()), 64'(up_exp(n, s)));
            req_on  = inj && (n == 1);
            req_off = inj && (n == 2 + s + R);
            tick();
        end
        req_on = 1'b0; req_off = 1'b0;
        chk("up_boot_addr", boot_addr_o, addr);
        chk("up_byp", 64'(byp_o), 64'(b));
    endtask

    task automatic power_down(input int sraw, input int b);
        int s = (sraw == 0) ? 1 : sraw;
        int eb = (TO_EN && b > T) ? T : b;
        bit tflag = TO_EN && (b > T);
        int off_t = eb + R + 2 + s;
        settle = CW'(sraw); busy = 1'b1; req_off = 1'b1;
        tick();
        req_off = 1'b0;
        for (int n = 1; n <= off_t + 1; n++) begin
            chk("down_outs", 64'(outv()), 64'(down_exp(n, s, eb, tflag)));
            if (n == b) busy = 1'b0;
            if (n == eb + R + 2) settle = CW'($urandom);
            tick();
        end
        busy = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_on = 1'b0; req_off = 1'b0; byp = 1'b1; busy = 1'b0;
        boot_addr = {$urandom, $urandom}; settle = 8'd4;
        tick(); tick();
        chk("reset_outs", 64'(outv()), 64'd0);
        chk("reset_addr", boot_addr_o, 64'd0);
        chk("reset_byp", 64'(byp_o), 64'd0);
        rst = 1'b0;
        tick();
        chk("off_idle", 64'(outv()), 64'd0);

        req_on = 1'b1; req_off = 1'b1;
        tick(); chk("off_both", 64'(outv()), 64'd0);
        tick(); chk("off_both2", 64'(outv()), 64'd0);
        req_on = 1'b0;
        tick(); chk("off_reqoff", 64'(outv()), 64'd0);
        req_off = 1'b0;

        power_up(4, 1'b0, 1'b0);

        req_on = 1'b1; req_off = 1'b1;
        tick(); chk("on_both", 64'(outv()), 64'b1111_0100);
        req_off = 1'b0;
        tick(); chk("on_reqon", 64'(outv()), 64'b1111_0100);
        req_on = 1'b0;

        power_down(4, 10);
        power_up(0, 1'b0, 1'b0);
        power_down(0, 1);
        power_up(int'($urandom_range(1, 5)), 1'b1, 1'b0);
        power_down(int'($urandom_range(1, 5)), int'($urandom_range(1, 5)));
        power_up(int'($urandom_range(1, 5)), 1'b0, 1'b1);
        power_up(3, 1'b0, 1'b0);
        power_down(2, 250);
        for (int i = 0; i < 3; i++) begin
            power_up(int'($urandom_range(0, 7)), 1'b0, 1'b0);
            power_down(int'($urandom_range(0, 7)), int'($urandom_range(1, 20)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
